uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmit stage directly downstream of the baud tick generator; consumes its one-cycle `baud_clk_en` strobe (9600 Bd at 50 MHz) and serialises bytes onto `tx`.
- Accepts bytes over a valid/ready handshake into a one-entry holding buffer, so back-to-back frames leave no idle gap.
- Frame: 1 start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY_EN, 0, 1 = append parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- baud_clk_en  input  1  one-cycle bit-period strobe from the baud tick generator.
- tx_data  input  DATA_BITS  byte to send; sampled on accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding buffer empty; a byte is accepted on a cycle where tx_valid && tx_ready.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high while a frame is on the line (state != IDLE).
- tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (async, rst_n = 0):
  - tx = 1, tx_ready = 1, tx_busy = 0, tx_done = 0.
  - FSM = IDLE, buffer cleared, all counters = 0.
  - Reset mid-frame aborts the frame immediately; line returns high; any buffered byte is discarded.
- All outputs are registered. The FSM advances only on cycles where baud_clk_en = 1. Each state is the bit currently driven on `tx`, so every bit lasts exactly one tick interval.
- Handshake:
  - Accept sets buf_full and drops tx_ready on the next cycle.
  - tx_valid while tx_ready = 0 is ignored; the sender holds the data.
  - Accept and load never coincide, because load requires buf_full = 1.
- Load (buffer → shift register): clears buf_full and computes parity from the loaded data as XOR of the data bits, inverted when PARITY_ODD = 1.
- States and transitions (each taken on a tick):
  - IDLE: tx = 1. If buf_full, load and go to START, tx <= 0. Otherwise stay. A byte accepted between ticks waits for the next tick; start-bit latency is ≤ 1 tick interval + 1 cycle.
  - START: tx <= shift[0], bit_cnt <= 0, go to DATA.
  - DATA:
    - If bit_cnt == DATA_BITS-1: go to PARITY (tx <= parity) when PARITY_EN = 1, else STOP (tx <= 1, stop_cnt <= 0).
    - Otherwise shift right, tx <= next bit, bit_cnt++.
  - PARITY: tx <= 1, stop_cnt <= 0, go to STOP.
  - STOP:
    - If stop_cnt == STOP_BITS-1: pulse tx_done. If buf_full, load and go to START with tx <= 0 (back-to-back); else go to IDLE with tx <= 1.
    - Otherwise stop_cnt++.
- Frame length = 1 + DATA_BITS + PARITY_EN + STOP_BITS ticks exactly.
- bit_cnt is 3 bits and stop_cnt is 1 bit; neither wraps past its terminal value.
- baud_clk_en asserted on consecutive cycles is legal: each asserted cycle is one bit period.
- baud_clk_en held at 0 freezes the FSM and `tx`; the handshake still operates.

Decomposition:
- Package `uart_pkg` holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - shared constants CLK_FREQ = 50_000_000 and BAUD_RATE = 9600;
  - default frame constants for DATA_BITS, PARITY_EN and STOP_BITS.
- No sub-module: the parity XOR is inline. The clock divider and uart_tx are sibling instances in the top level.

Test Plan:
- 8N1, 0x55, tick every 4 cycles → after start bit 0, tx shows 1,0,1,0,1,0,1,0, then stop 1; tx_done pulses once; frame spans 10 ticks; tx_busy high for exactly 10 tick intervals.
- Back-to-back 0xA5 then 0x3C (second byte offered while the first is shifting) → tx_ready reopens when 0xA5 is loaded; 0x3C's start bit follows 0xA5's stop bit with no idle tick; 20 ticks total.
- PARITY_EN = 1, 0x07 → parity bit 1 with even parity, 0 with PARITY_ODD = 1; frame = 11 ticks. STOP_BITS = 2 → stop held for 2 ticks, frame = 12 ticks.
- baud_clk_en held 0, tx_valid held with 0x11 then 0x22 → 0x11 accepted; tx_ready = 0 afterwards; 0x22 not accepted; tx stays 1 and tx_busy stays 0 until the first tick.
- rst_n asserted during data bit 3 of 0x0F with 0xF0 buffered → tx = 1 and tx_ready = 1 immediately; after release, no remnant of 0x0F or 0xF0 appears on tx.
- Accept at the same cycle as a tick in IDLE → start bit begins on the following tick, not the same one; measured latency is within 1 tick interval + 1 cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path.
package uart_pkg;

  // System clock and line rate shared with the baud tick generator.
  localparam int unsigned CLK_FREQ  = 50_000_000;
  localparam int unsigned BAUD_RATE = 9600;

  // Default frame format: 8N1.
  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_PARITY_EN = 0;
  localparam int unsigned DEF_STOP_BITS = 1;

  // Transmitter state; each state names the bit currently on the line.
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding buffer in front of a tick-paced frame serialiser.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned PARITY_EN  = DEF_PARITY_EN,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_clk_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY_ODD != 0);

  state_t               state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 buf_full_q, buf_full_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 accept;
  logic                 load;

  // Next-state logic: handshake into the buffer, frame sequencing on ticks.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    buf_d      = buf_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    load       = 1'b0;
    // ready_q mirrors !buf_full_q, so accept can never overlap a load.
    accept     = tx_valid && ready_q;

    if (baud_clk_en) begin
      case (state_q)
        IDLE: begin
          if (buf_full_q) begin
            load    = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end
        end
        START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d    = STOP;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
        STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d = 1'b1;
            if (buf_full_q) begin
              // Next byte already waiting: start bit follows immediately.
              load    = 1'b1;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    if (load) begin
      shift_d  = buf_q;
      parity_d = (^buf_q) ^ ODD;
    end

    if (accept) begin
      buf_d = tx_data;
    end

    if (accept) begin
      buf_full_d = 1'b1;
    end else if (load) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end

    ready_d = ~buf_full_d;
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset aborts any frame and drops the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four frame formats side by side, checked by a line-level receiver model.
module tb_uart_tx;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_clk_en = 1'b0;
  logic [7:0] tx_data [N];
  logic       tx_valid [N];
  logic       tx_ready [N];
  logic       tx_line [N];
  logic       tx_busy [N];
  logic       tx_done [N];

  int checks = 0;
  int errors = 0;

  // Per-tick line log and per-cycle event counters.
  bit  log_tx [N][$];
  bit  log_busy [N][$];
  bit  log_rdy [N][$];
  int  done_cnt [N];
  int  busy_cyc [N];
  logic tick_s = 1'b0;

  int tick_div = 4;
  bit tick_on = 1'b1;
  bit tick_rand = 1'b0;
  int tick_cnt = 0;

  logic [7:0] rq [N][$];

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_clk_en(baud_clk_en), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx(tx_line[0]), .tx_busy(tx_busy[0]),
    .tx_done(tx_done[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .baud_clk_en(baud_clk_en), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx(tx_line[1]), .tx_busy(tx_busy[1]),
    .tx_done(tx_done[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .rst_n(rst_n), .baud_clk_en(baud_clk_en), .tx_data(tx_data[2]),
    .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .tx(tx_line[2]), .tx_busy(tx_busy[2]),
    .tx_done(tx_done[2]));
  uart_tx #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_5n1 (
    .clk(clk), .rst_n(rst_n), .baud_clk_en(baud_clk_en), .tx_data(tx_data[3][4:0]),
    .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]), .tx(tx_line[3]), .tx_busy(tx_busy[3]),
    .tx_done(tx_done[3]));

  function automatic int db(input int i);
    return (i == 3) ? 5 : 8;
  endfunction
  function automatic int pe(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction
  function automatic bit po(input int i);
    return (i == 2);
  endfunction
  function automatic int sb(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  // Reference frame, bit j = line level during the j-th tick of the frame.
  function automatic logic [15:0] exp_frame(input int i, input logic [7:0] d);
    logic [15:0] f;
    logic par;
    f = '1;
    par = 1'b0;
    f[0] = 1'b0;
    for (int k = 0; k < db(i); k++) begin
      f[1 + k] = d[k];
      par ^= d[k];
    end
    if (pe(i) != 0) f[1 + db(i)] = po(i) ? ~par : par;
    return f;
  endfunction

  function automatic int first_start(input int i);
    for (int p = 0; p < log_tx[i].size(); p++) if (log_tx[i][p] == 1'b0) return p;
    return -1;
  endfunction

  function automatic int busy_ticks(input int i);
    int n = 0;
    foreach (log_busy[i][p]) if (log_busy[i][p]) n++;
    return n;
  endfunction

  // Baud strobe source: fixed divider or random (including back-to-back strobes).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!tick_on) begin
        baud_clk_en = 1'b0;
        tick_cnt = 0;
      end else if (tick_rand) begin
        baud_clk_en = ($urandom_range(0, 2) == 0);
      end else if (tick_cnt >= tick_div - 1) begin
        baud_clk_en = 1'b1;
        tick_cnt = 0;
      end else begin
        baud_clk_en = 1'b0;
        tick_cnt++;
      end
    end
  end

  always @(posedge clk) tick_s <= baud_clk_en;

  // Monitor: record line state after every tick, count done pulses and busy cycles.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (tick_s) begin
          log_tx[i].push_back(tx_line[i]);
          log_busy[i].push_back(tx_busy[i]);
          log_rdy[i].push_back(tx_ready[i]);
        end
        if (tx_done[i]) done_cnt[i]++;
        if (tx_busy[i]) busy_cyc[i]++;
      end
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < N; i++) begin
      log_tx[i].delete();
      log_busy[i].delete();
      log_rdy[i].delete();
      done_cnt[i] = 0;
      busy_cyc[i] = 0;
    end
  endtask

  task automatic send(input int i, input logic [7:0] d);
    bit ok = 1'b0;
    @(posedge clk);
    #2;
    tx_data[i] = d;
    tx_valid[i] = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (tx_ready[i]) begin
        @(posedge clk);
        #2;
        ok = 1'b1;
        break;
      end
    end
    tx_valid[i] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept[%0d]: byte 0x%02h never accepted, want accepted", i, d);
    end
  endtask

  task automatic wait_done(input int i, input int n, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      #1;
      if (done_cnt[i] >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d done pulses, want %0d", name, done_cnt[i], n);
    end
  endtask

  // Receiver model: skip idle highs, slice fixed-length frames, compare to reference.
  task automatic check_frames(input int i, input logic [7:0] exp_q[$], input bit no_gap,
                              input string name);
    int p;
    int gap;
    int flen;
    bit extra;
    logic [15:0] got;
    logic [15:0] exp;
    p = 0;
    flen = 1 + db(i) + pe(i) + sb(i);
    foreach (exp_q[k]) begin
      gap = 0;
      while (p < log_tx[i].size() && log_tx[i][p] == 1'b1) begin
        p++;
        gap++;
      end
      if (no_gap && k > 0) begin
        checks++;
        if (gap != 0) begin
          errors++;
          $display("FAIL %s gap before frame %0d: got %0d idle ticks, want 0", name, k, gap);
        end
      end
      checks++;
      if (p + flen > log_tx[i].size()) begin
        errors++;
        $display("FAIL %s frame %0d missing: got %0d ticks left, want %0d", name, k,
                 log_tx[i].size() - p, flen);
        return;
      end
      got = '1;
      for (int j = 0; j < flen; j++) got[j] = log_tx[i][p + j];
      p += flen;
      exp = exp_frame(i, exp_q[k]);
      if (got !== exp) begin
        errors++;
        $display("FAIL %s frame %0d (0x%02h): got bits %b, want %b", name, k, exp_q[k], got, exp);
      end
    end
    extra = 1'b0;
    while (p < log_tx[i].size()) begin
      if (log_tx[i][p] == 1'b0) extra = 1'b1;
      p++;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL %s trailing: got a low bit after the last frame, want idle high", name);
    end
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({tx_line[i], tx_ready[i], tx_busy[i], tx_done[i]} !== 4'b1100) begin
        errors++;
        $display("FAIL reset[%0d]: got tx,rdy,busy,done=%b%b%b%b, want 1100", i, tx_line[i],
                 tx_ready[i], tx_busy[i], tx_done[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_8n1_55();
    logic [7:0] q[$];
    tick_div = 4;
    clear_logs();
    send(0, 8'h55);
    wait_done(0, 1, "8n1");
    repeat (12) @(negedge clk);
    q = '{8'h55};
    check_frames(0, q, 1'b0, "8n1_55");
    checks++;
    if (done_cnt[0] !== 1) begin
      errors++;
      $display("FAIL 8n1_done: got %0d pulses, want 1", done_cnt[0]);
    end
    checks++;
    if (busy_cyc[0] !== 40) begin
      errors++;
      $display("FAIL 8n1_busy_cycles: got %0d, want 40", busy_cyc[0]);
    end
    checks++;
    if (busy_ticks(0) !== 10) begin
      errors++;
      $display("FAIL 8n1_frame_ticks: got %0d, want 10", busy_ticks(0));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int s;
    tick_div = 4;
    clear_logs();
    send(0, 8'hA5);
    send(0, 8'h3C);
    wait_done(0, 2, "b2b");
    repeat (12) @(negedge clk);
    q = '{8'hA5, 8'h3C};
    check_frames(0, q, 1'b1, "b2b");
    checks++;
    if (busy_ticks(0) !== 20) begin
      errors++;
      $display("FAIL b2b_ticks: got %0d, want 20", busy_ticks(0));
    end
    s = first_start(0);
    checks++;
    if (s < 0 || log_rdy[0][s] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_on_load: got start index %0d ready %0b, want ready 1", s,
               (s >= 0) ? log_rdy[0][s] : 1'b0);
    end
  endtask

  task automatic test_parity();
    logic [7:0] q[$];
    int s;
    tick_div = 3;
    clear_logs();
    send(1, 8'h07);
    send(2, 8'h07);
    wait_done(1, 1, "par_even");
    wait_done(2, 1, "par_odd");
    repeat (12) @(negedge clk);
    q = '{8'h07};
    check_frames(1, q, 1'b0, "par_even");
    check_frames(2, q, 1'b0, "par_odd_2stop");
    s = first_start(1);
    checks++;
    if (s < 0 || log_tx[1][s + 9] !== 1'b1) begin
      errors++;
      $display("FAIL par_even_bit: got %0b, want 1", (s >= 0) ? log_tx[1][s + 9] : 1'b0);
    end
    s = first_start(2);
    checks++;
    if (s < 0 || log_tx[2][s + 9] !== 1'b0) begin
      errors++;
      $display("FAIL par_odd_bit: got %0b, want 0", (s >= 0) ? log_tx[2][s + 9] : 1'b1);
    end
    checks++;
    if (busy_ticks(1) !== 11 || busy_ticks(2) !== 12) begin
      errors++;
      $display("FAIL par_frame_ticks: got %0d/%0d, want 11/12", busy_ticks(1), busy_ticks(2));
    end
  endtask

  task automatic test_hold_no_tick();
    logic [7:0] q[$];
    bit bad;
    tick_on = 1'b0;
    repeat (3) @(posedge clk);
    clear_logs();
    send(0, 8'h11);
    @(posedge clk);
    #2;
    tx_data[0] = 8'h22;
    tx_valid[0] = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx_ready[0] !== 1'b0 || tx_line[0] !== 1'b1 || tx_busy[0] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_frozen: got rdy,tx,busy=%b%b%b at some cycle, want 010", tx_ready[0],
               tx_line[0], tx_busy[0]);
    end
    @(posedge clk);
    #2;
    tx_valid[0] = 1'b0;
    tick_on = 1'b1;
    tick_div = 4;
    wait_done(0, 1, "hold");
    repeat (16) @(negedge clk);
    q = '{8'h11};
    check_frames(0, q, 1'b0, "hold_only_0x11");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] none[$];
    int s;
    bit reached;
    tick_div = 4;
    clear_logs();
    send(0, 8'h0F);
    send(0, 8'hF0);
    reached = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      #1;
      s = first_start(0);
      if (s >= 0 && log_tx[0].size() >= s + 5) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached || tx_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_setup: got reached=%0b ready=%0b, want 1 and 0", reached,
               tx_ready[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_line[0], tx_ready[0], tx_busy[0]} !== 3'b110) begin
      errors++;
      $display("FAIL rst_mid_async: got tx,rdy,busy=%b%b%b, want 110", tx_line[0], tx_ready[0],
               tx_busy[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (120) @(negedge clk);
    check_frames(0, none, 1'b0, "rst_mid_no_remnant");
    checks++;
    if (done_cnt[0] !== 0 || busy_cyc[0] !== 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got done=%0d busy_cycles=%0d, want 0 and 0", done_cnt[0],
               busy_cyc[0]);
    end
  endtask

  task automatic test_accept_on_tick();
    logic [7:0] q[$];
    bit found;
    bit got_start;
    int lat;
    tick_div = 8;
    clear_logs();
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (baud_clk_en && tx_ready[0] && !tx_busy[0]) begin
        found = 1'b1;
        break;
      end
    end
    tx_data[0] = 8'h5A;
    tx_valid[0] = found;
    @(posedge clk);
    #2;
    tx_valid[0] = 1'b0;
    lat = 0;
    got_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx_line[0] === 1'b0) begin
        got_start = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    checks++;
    if (!found || !got_start || lat != 8) begin
      errors++;
      $display("FAIL accept_on_tick_latency: got %0d cycles (start seen %0b), want 8", lat,
               got_start);
    end
    wait_done(0, 1, "accept_on_tick");
    repeat (20) @(negedge clk);
    q = '{8'h5A};
    check_frames(0, q, 1'b0, "accept_on_tick");
  endtask

  task automatic rand_stream(input int i);
    logic [7:0] d;
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      rq[i].push_back(d);
      send(i, d);
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
  endtask

  task automatic test_random();
    tick_rand = 1'b1;
    clear_logs();
    for (int i = 0; i < N; i++) rq[i].delete();
    fork
      rand_stream(0);
      rand_stream(1);
      rand_stream(2);
      rand_stream(3);
    join
    for (int i = 0; i < N; i++) wait_done(i, 6, "random");
    repeat (30) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_frames(i, rq[i], 1'b0, $sformatf("random[%0d]", i));
      checks++;
      if (done_cnt[i] !== 6) begin
        errors++;
        $display("FAIL random_done[%0d]: got %0d pulses, want 6", i, done_cnt[i]);
      end
    end
    tick_rand = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      tx_data[i] = 8'h00;
      tx_valid[i] = 1'b0;
      done_cnt[i] = 0;
      busy_cyc[i] = 0;
    end
    test_reset();
    test_8n1_55();
    test_back_to_back();
    test_parity();
    test_hold_no_tick();
    test_reset_mid_frame();
    test_accept_on_tick();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
